movavg_capture: RTL

Downstream result-capture stage for the `movavg` bit-serial moving-average core. `movavg` accepts one 64-bit sample per 64-cycle frame and presents the 4-tap sum of the previous frame on `dout`. This block:
- tracks frame phase;
- samples `dout` once per frame at a fixed offset;
- scales the sum to an average (÷4);
- delivers results through a valid/ready interface backed by a 2-entry buffer with sticky overflow detection.

---
 rtl/movavg_pkg.sv | 23 ++
 rtl/movavg_capture_fifo.sv | 53 +++++
 rtl/movavg_capture.sv | 80 ++++++++
 3 files changed

// File: rtl/movavg_pkg.sv
// Shared constants and types for the movavg core and its capture stage.
// Defining MOVAVG_CAPTURE_ROUND_EN switches movavg_scale from truncation to round-half-up.
package movavg_pkg;

  localparam int MOVAVG_W         = 64;
  localparam int MOVAVG_FRAME_LEN = 64;
  localparam int MOVAVG_TAPS      = 4;
  localparam int MOVAVG_SHIFT     = 2;

  typedef logic [MOVAVG_W-1:0] movavg_word_t;

  // The rounding bias is added one bit wider so an all-ones sum cannot wrap.
  function automatic movavg_word_t movavg_scale(input movavg_word_t sum);
`ifdef MOVAVG_CAPTURE_ROUND_EN
    logic [MOVAVG_W:0] biased;
    biased = {1'b0, sum} + (MOVAVG_W+1)'(MOVAVG_TAPS / 2);
    return movavg_word_t'(biased >> MOVAVG_SHIFT);
`else
    return sum >> MOVAVG_SHIFT;
`endif
  endfunction

endpackage

// File: rtl/movavg_capture_fifo.sv
// Two-entry synchronous FIFO; head is a registered mux, one-cycle push-to-visible latency.
// A push into a full FIFO is accepted only alongside a pop; the parent owns drop policy.
module movavg_capture_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // When full, wr_ptr equals rd_ptr, so a push+pop overwrites exactly the departing head.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 2'd1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/movavg_capture.sv
// Samples movavg dout once per frame, scales to an average, buffers 2 results; valid at phase CAPTURE_OFS+2.
// Drops a result pushed into a full buffer with no pop and sets sticky overflow; MOVAVG_CAPTURE_ROUND_EN enables rounding.
module movavg_capture
  import movavg_pkg::*;
#(
  parameter int  FRAME_LEN   = MOVAVG_FRAME_LEN,
  parameter int  CAPTURE_OFS = 4,
  parameter int  SKIP_FRAMES = 1,
  localparam int PHASE_W     = $clog2(FRAME_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  movavg_word_t       dout_in,
  output movavg_word_t       avg_out,
  output logic               avg_valid,
  input  logic               avg_ready,
  output logic [PHASE_W-1:0] phase,
  output logic               overflow
);

  localparam int SKIP_W = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  movavg_word_t       cap_q, cap_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;

  logic capture;
  logic skipping;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  assign avg_valid = !fifo_empty;
  assign pop       = avg_valid && avg_ready;
  assign phase     = phase_q;
  assign overflow  = ovf_q;

  always_comb begin
    phase_d  = (phase_q == PHASE_W'(FRAME_LEN - 1)) ? '0 : phase_q + 1'b1;
    capture  = (phase_q == PHASE_W'(CAPTURE_OFS));
    skipping = (skip_q < SKIP_W'(SKIP_FRAMES));
    cap_d    = capture ? dout_in : cap_q;
    // Captures taken while still skipping never become pushes, so they cannot overflow.
    pend_d   = capture && !skipping;
    skip_d   = (capture && skipping) ? skip_q + 1'b1 : skip_q;
    ovf_d    = ovf_q || (pend_q && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      skip_q  <= '0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      skip_q  <= skip_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  movavg_capture_fifo #(
    .W (MOVAVG_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pend_q),
    .din   (movavg_scale(cap_q)),
    .pop   (pop),
    .dout  (avg_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
